// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS_DEF = 8;
    localparam int unsigned MAX_DATA_BITS = 9;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    // Zero-extension does not change the parity, so one width serves every DATA_BITS.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; push when full and pop when empty are ignored.
module uart_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO and per-frame parity/stop configuration.
// Optional macro UART_TX_BREAK_EN adds break_req, which holds the idle line low.
module uart_tx_fifo_param
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_req,
`endif
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_BITS);

    tx_state_e            r_state;
    tx_state_e            w_state_next;
    logic                 r_tx;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_stop2;
    logic                 r_frame_done;

    logic                 w_tx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [IDX_W-1:0]     w_bit_idx_next;
    logic                 w_stop_cnt_next;
    logic                 w_par_en_next;
    logic                 w_par_bit_next;
    logic                 w_stop2_next;

    logic                 w_start_frame;
    logic                 w_frame_end;
    logic                 w_break;
    logic [1:0]           w_par_mode;
    logic [DATA_BITS-1:0] w_rdata;
    logic                 w_full;
    logic                 w_empty;

`ifdef UART_TX_BREAK_EN
    assign w_break = break_req;
`else
    assign w_break = 1'b0;
`endif

    uart_tx_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid),
        .pop   (w_start_frame),
        .wdata (s_data),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign s_ready    = !w_full;
    assign tx_busy    = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign tx         = (w_break && r_state == IDLE) ? 1'b0 : r_tx;
    assign w_par_mode = !cfg_parity_en ? PAR_NONE : (cfg_parity_odd ? PAR_ODD : PAR_EVEN);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Frame start pops the FIFO both from IDLE and at the end of STOP (back-to-back).
    always_comb begin
        w_state_next  = r_state;
        w_start_frame = 1'b0;
        w_frame_end   = 1'b0;
        if (baud_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_empty && !w_break) begin
                        w_state_next  = START;
                        w_start_frame = 1'b1;
                    end
                end
                START: w_state_next = DATA;
                DATA: begin
                    if (r_bit_idx >= BIT_LAST) w_state_next = r_par_en ? PARITY : STOP;
                end
                PARITY: w_state_next = STOP;
                STOP: begin
                    if (!(r_stop2 && !r_stop_cnt)) begin
                        w_frame_end = 1'b1;
                        if (!w_empty && !w_break) begin
                            w_state_next  = START;
                            w_start_frame = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx_next       = r_tx;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_par_en_next   = r_par_en;
        w_par_bit_next  = r_par_bit;
        w_stop2_next    = r_stop2;
        if (w_start_frame) begin
            w_tx_next      = 1'b0;
            w_shift_next   = w_rdata;
            w_par_en_next  = (w_par_mode != PAR_NONE);
            w_par_bit_next = calc_parity(MAX_DATA_BITS'(w_rdata), w_par_mode == PAR_ODD);
            w_stop2_next   = cfg_stop2;
        end else if (baud_tick) begin
            case (r_state)
                START: begin
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = IDX_W'(1);
                end
                DATA: begin
                    if (r_bit_idx < BIT_LAST) begin
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end else if (r_par_en) begin
                        w_tx_next = r_par_bit;
                    end else begin
                        w_tx_next       = 1'b1;
                        w_stop_cnt_next = 1'b0;
                    end
                end
                PARITY: begin
                    w_tx_next       = 1'b1;
                    w_stop_cnt_next = 1'b0;
                end
                STOP: begin
                    if (!w_frame_end) w_stop_cnt_next = 1'b1;
                    else              w_tx_next       = TX_IDLE_LEVEL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx         <= TX_IDLE_LEVEL;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_cnt   <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_stop2      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx         <= w_tx_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_stop_cnt   <= w_stop_cnt_next;
            r_par_en     <= w_par_en_next;
            r_par_bit    <= w_par_bit_next;
            r_stop2      <= w_stop2_next;
            r_frame_done <= w_frame_end;
        end
    end

endmodule
